// File: rtl/hlsm_pkg.sv
// hlsm_pkg: shared types and defaults for the HLSM launcher.
// Holds the launcher state encoding and parameter defaults.
package hlsm_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_WAIT   = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   localparam int DW_DEF      = 16;
   localparam int TIMEOUT_DEF = 32;
   localparam int CNT_W       = 8;

endpackage

// File: rtl/hlsm_sum5.sv
// hlsm_sum5: expected result for the attached HLSM.
// Five-operand sum wrapped modulo 2^DW.
module hlsm_sum5
   import hlsm_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  logic [DW-1:0] c_i,
   input  logic [DW-1:0] d_i,
   input  logic [DW-1:0] e_i,
   output logic [DW-1:0] sum_o
);

   // Two's complement addition modulo 2^DW gives the same low DW
   // bits as a full-precision signed sum truncated to DW bits.
   always_comb begin
      sum_o = a_i + b_i + c_i + d_i + e_i;
   end

endmodule

// File: rtl/hlsm_launcher.sv
// hlsm_launcher: hands operand sets to a datapath HLSM, waits
// for Done with a timeout and returns a checked response.
module hlsm_launcher
   import hlsm_pkg::*;
#(
   parameter int DW      = DW_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [DW-1:0] req_a,
   input  logic [DW-1:0] req_b,
   input  logic [DW-1:0] req_c,
   input  logic [DW-1:0] req_d,
   input  logic [DW-1:0] req_e,
   output logic          Start,
   input  logic          Done,
   output logic [DW-1:0] a,
   output logic [DW-1:0] b,
   output logic [DW-1:0] c,
   output logic [DW-1:0] d,
   output logic [DW-1:0] e,
   input  logic [DW-1:0] i,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          rsp_timeout,
   output logic          rsp_err,
   output logic          busy
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [DW-1:0]    a_q, b_q, c_q, d_q, e_q;
   logic [DW-1:0]    exp_sum;
   logic             start_q;
   logic             ready_q;
   logic             busy_q;
   logic             rsp_valid_q;
   logic [DW-1:0]    rsp_data_q;
   logic             rsp_timeout_q;
   logic             rsp_err_q;

   hlsm_sum5 #(
      .DW(DW)
   ) u_sum5 (
      .a_i  (a_q),
      .b_i  (b_q),
      .c_i  (c_q),
      .d_i  (d_q),
      .e_i  (e_q),
      .sum_o(exp_sum)
   );

   // Next wait-counter value while idling in WAIT.
   always_comb begin
      cnt_d = cnt_q + 1'b1;
   end

   // Launcher FSM; every output is a register updated here.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         a_q           <= '0;
         b_q           <= '0;
         c_q           <= '0;
         d_q           <= '0;
         e_q           <= '0;
         start_q       <= 1'b0;
         ready_q       <= 1'b1;
         busy_q        <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_timeout_q <= 1'b0;
         rsp_err_q     <= 1'b0;
      end else begin
         start_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  a_q     <= req_a;
                  b_q     <= req_b;
                  c_q     <= req_c;
                  d_q     <= req_d;
                  e_q     <= req_e;
                  start_q <= 1'b1;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               cnt_q   <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // Done takes priority over an expiring timeout.
               if (Done) begin
                  rsp_data_q    <= i;
                  rsp_timeout_q <= 1'b0;
                  rsp_err_q     <= (i != exp_sum);
                  rsp_valid_q   <= 1'b1;
                  state_q       <= S_RESP;
               end else if (cnt_q == CNT_LAST) begin
                  rsp_data_q    <= '0;
                  rsp_timeout_q <= 1'b1;
                  rsp_err_q     <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= S_RESP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  ready_q     <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign req_ready   = ready_q;
   assign Start       = start_q;
   assign busy        = busy_q;
   assign a           = a_q;
   assign b           = b_q;
   assign c           = c_q;
   assign d           = d_q;
   assign e           = e_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_data    = rsp_data_q;
   assign rsp_timeout = rsp_timeout_q;
   assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_hlsm_launcher.sv
// tb_hlsm_launcher: directed bench for hlsm_launcher with a
// behavioural HLSM responder of adjustable latency and result.
module tb_hlsm_launcher;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [15:0] req_a = '0, req_b = '0, req_c = '0;
   logic [15:0] req_d = '0, req_e = '0;
   logic        Start;
   logic        Done = 1'b0;
   logic [15:0] a, b, c, d, e;
   logic [15:0] i = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_data;
   logic        rsp_timeout;
   logic        rsp_err;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // responder: mode 0 sums, 1 never answers, 2 returns 99
   int mode = 0;
   int lat  = 4;
   int rcnt = 0;
   bit pend = 0;

   hlsm_launcher dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_c      (req_c),
      .req_d      (req_d),
      .req_e      (req_e),
      .Start      (Start),
      .Done       (Done),
      .a          (a),
      .b          (b),
      .c          (c),
      .d          (d),
      .e          (e),
      .i          (i),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_timeout(rsp_timeout),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 Clk = ~Clk;

   // HLSM model: Done rises lat cycles after Start is seen.
   always @(negedge Clk or posedge Rst) begin
      if (Rst) begin
         Done = 1'b0;
         pend = 0;
         rcnt = 0;
      end else if (Start) begin
         Done = 1'b0;
         pend = 1;
         rcnt = 0;
      end else if (pend) begin
         rcnt = rcnt + 1;
         if (rcnt == lat) begin
            pend = 0;
            if (mode == 0) begin
               Done = 1'b1;
               i = a + b + c + d + e;
            end else if (mode == 2) begin
               Done = 1'b1;
               i = 16'd99;
            end
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic send(input logic [15:0] va, input logic [15:0] vb,
                       input logic [15:0] vc, input logic [15:0] vd,
                       input logic [15:0] ve);
      req_a = va; req_b = vb; req_c = vc;
      req_d = vd; req_e = ve;
      req_valid = 1'b1;
      @(posedge Clk); #1;
      req_valid = 1'b0;
      chk("start_pulse", Start, 1);
      chk("ready_low", req_ready, 0);
   endtask

   task automatic wait_rsp(output int n, output int extra);
      n = 0;
      extra = 0;
      while (!rsp_valid && n < 100) begin
         @(posedge Clk); #1;
         n++;
         if (Start) extra++;
      end
      chk("rsp_arrived", rsp_valid, 1);
   endtask

   task automatic accept();
      rsp_ready = 1'b1;
      @(posedge Clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 0);
      chk("ready_back", req_ready, 1);
      chk("busy_clear", busy, 0);
   endtask

   int n, extra, seen;
   logic [15:0] hold_d;

   initial begin
      // reset state
      repeat (2) @(posedge Clk);
      #1;
      chk("rst_start", Start, 0);
      chk("rst_valid", rsp_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_a", a, 0);
      Rst = 1'b0;
      @(posedge Clk); #1;
      chk("post_rst_ready", req_ready, 1);

      // 1..5 summed in 4 cycles, Start one cycle after accept
      mode = 0; lat = 4;
      send(16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
      chk("busy_set", busy, 1);
      chk("cap_e", e, 5);
      wait_rsp(n, extra);
      chk("lat_sum", n, 5);
      chk("start_once", extra, 0);
      chk("sum_data", rsp_data, 15);
      chk("sum_to", rsp_timeout, 0);
      chk("sum_err", rsp_err, 0);
      accept();

      // wrap case, then hold rsp_ready low for five cycles
      send(16'd32767, 16'd1, 16'd0, 16'd0, 16'd0);
      wait_rsp(n, extra);
      chk("wrap_data", rsp_data, 16'h8000);
      chk("wrap_err", rsp_err, 0);
      hold_d = rsp_data;
      for (int k = 0; k < 5; k++) begin
         @(posedge Clk); #1;
         chk("hold_valid", rsp_valid, 1);
         chk("hold_data", rsp_data, hold_d);
         chk("hold_to", rsp_timeout, 0);
         chk("hold_ready", req_ready, 0);
         chk("hold_start", Start, 0);
      end
      chk("hold_a", a, 16'd32767);
      accept();

      // Done never arrives: 1 LAUNCH + 32 WAIT cycles
      mode = 1;
      send(16'd7, 16'd7, 16'd7, 16'd7, 16'd7);
      wait_rsp(n, extra);
      chk("to_lat", n, 33);
      chk("to_flag", rsp_timeout, 1);
      chk("to_data", rsp_data, 0);
      chk("to_err", rsp_err, 0);
      accept();

      // Done on the last WAIT cycle beats the timeout
      mode = 0; lat = 32;
      send(16'd10, 16'd20, 16'd30, 16'd40, 16'd50);
      wait_rsp(n, extra);
      chk("race_lat", n, 33);
      chk("race_to", rsp_timeout, 0);
      chk("race_data", rsp_data, 150);
      accept();

      // wrong result from stub
      mode = 2; lat = 4;
      send(16'd1, 16'd2, 16'd3, 16'd4, 16'd5);
      wait_rsp(n, extra);
      chk("bad_data", rsp_data, 99);
      chk("bad_err", rsp_err, 1);
      accept();

      // reset mid-WAIT, asynchronous to the clock
      mode = 0; lat = 6;
      send(16'd3, 16'd3, 16'd3, 16'd3, 16'd3);
      @(posedge Clk); #1;
      @(posedge Clk); #3;
      Rst = 1'b1;
      #1;
      chk("mid_busy", busy, 0);
      chk("mid_ready", req_ready, 1);
      chk("mid_start", Start, 0);
      chk("mid_valid", rsp_valid, 0);
      chk("mid_a", a, 0);
      chk("mid_err", rsp_err, 0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge Clk); #1;
         if (rsp_valid || busy) seen++;
      end
      chk("no_rsp", seen, 0);

      // normal request after reset
      lat = 4;
      send(16'd2, 16'd4, 16'd6, 16'd8, 16'd10);
      wait_rsp(n, extra);
      chk("after_lat", n, 5);
      chk("after_data", rsp_data, 30);
      chk("after_err", rsp_err, 0);
      accept();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/hlsm_launcher.md
HLSM_LAUNCHER -- requirements
Module: hlsm_launcher

Interface
REQ-001 Parameter DW, default 16: operand/result width, signed two's complement.
REQ-002 Parameter TIMEOUT, default 32: maximum WAIT cycles before the transaction is abandoned; legal range 2..255.
REQ-003 Clk  input  1  single clock, rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  1  upstream offers an operand set.
REQ-006 req_ready  output  1  launcher can accept an operand set.
REQ-007 req_a, req_b, req_c, req_d, req_e  input  DW each  operand set, signed.
REQ-008 Start  output  1  one-cycle launch pulse to the datapath HLSM.
REQ-009 Done  input  1  level completion flag from the HLSM.
REQ-010 a, b, c, d, e  output  DW each  operands driven to the HLSM, signed.
REQ-011 i  input  DW  HLSM result, signed, valid while Done=1.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  downstream accepts the response.
REQ-014 rsp_data  output  DW  captured result.
REQ-015 rsp_timeout  output  1  transaction abandoned, no Done seen.
REQ-016 rsp_err  output  1  captured result differs from expected sum.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 States: IDLE, LAUNCH, WAIT, RESP; every transition occurs on the rising edge of Clk.
REQ-019 IDLE: req_ready=1; when req_valid=1, register req_a..req_e into a..e, go to LAUNCH.
REQ-020 LAUNCH: Start=1 for exactly this one cycle; next state is WAIT.
REQ-021 Start=0 in every state other than LAUNCH.
REQ-022 a..e hold their values from the IDLE capture until the next capture; they are never changed during LAUNCH, WAIT or RESP.
REQ-023 WAIT: wait counter starts at 0 on entry and increments once per cycle.
REQ-024 Done is sampled only in WAIT; Done in IDLE, LAUNCH or RESP has no effect.
REQ-025 WAIT with Done=1: rsp_data<=i, rsp_timeout<=0, rsp_err<=(i != expected), go to RESP.
REQ-026 WAIT with Done=0 and counter=TIMEOUT-1: rsp_data<=0, rsp_timeout<=1, rsp_err<=0, go to RESP.
REQ-027 If Done=1 and the timeout condition hold in the same cycle, Done wins.
REQ-028 Expected = a+b+c+d+e computed at full precision and truncated to DW bits, i.e. wrap modulo 2^DW.
REQ-029 RESP: rsp_valid=1; rsp_data, rsp_timeout and rsp_err are held stable until rsp_ready=1; on rsp_ready=1, go to IDLE.
REQ-030 req_ready=0 in every state other than IDLE; operand sets are not queued.
REQ-031 Minimum turnaround: a request accepted in cycle N gives Start in cycle N+1.

Reset
REQ-032 Rst=1 forces IDLE immediately, independent of Clk, including mid-transaction.
REQ-033 Reset values: Start=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, rsp_err=0, busy=0, a..e=0, wait counter=0.
REQ-034 req_ready=1 in the first cycle after Rst deasserts.
REQ-035 A transaction interrupted by reset produces no response.

Structure
REQ-036 Shared package hlsm_pkg holds the state enumeration, the DW default (16) and the TIMEOUT default (32).
REQ-037 One sub-module, hlsm_sum5, computes the DW-bit wrapped expected sum from a..e.
REQ-038 The FSM, wait counter and response registers reside in hlsm_launcher.

Verification
REQ-039 Operands 1,2,3,4,5 with a 4-cycle summing HLSM attached -> Start one cycle after acceptance; rsp_data=15, rsp_timeout=0, rsp_err=0.
REQ-040 Operands 32767,1,0,0,0 -> rsp_data=-32768, rsp_err=0 (wrap accepted).
REQ-041 Done tied low, TIMEOUT=32 -> rsp_valid after 32 WAIT cycles with rsp_timeout=1, rsp_data=0.
REQ-042 Stub responder returns 99 for operands 1..5 -> rsp_data=99, rsp_err=1.
REQ-043 rsp_ready held low 5 cycles in RESP -> response fields stable, req_ready=0, Start=0 throughout.
REQ-044 Rst pulsed mid-WAIT -> immediate IDLE, all outputs at reset values, no response; next request completes normally.
